instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/mips_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants: word width, reset PC, FSM encoding, buffer entry.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_KILL = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory, instruction-delivery and redirect signals of the fetch unit.
interface instr_fetch_unit_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two FIFO of {pc, inst} entries with synchronous flush.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding prefetcher feeding a FIFO, with redirect/kill handling.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] fpc, fpc_d;
  logic [XLEN-1:0] pend_pc, pend_pc_d;
  logic            outstanding, outstanding_d;
  logic            req_c;
  logic            accept_c;
  logic            resp_c;
  logic            push_c;
  logic            pop_c;
  logic            room_c;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    head;
  fetch_entry_t    wentry;

  // Occupancy counts in-flight requests so a returning word always has a slot.
  assign room_c   = !fifo_full && ((fifo_count + CW'(outstanding)) < CW'(DEPTH));
  assign pop_c    = !fifo_empty && bus.inst_ready;
  assign wentry   = '{pc: pend_pc, inst: bus.imem_rdata};

  always_comb begin
    state_d       = state;
    fpc_d         = fpc;
    pend_pc_d     = pend_pc;
    outstanding_d = outstanding;
    req_c         = 1'b0;
    accept_c      = 1'b0;
    resp_c        = 1'b0;
    push_c        = 1'b0;

    // A new request may go out in the same cycle the previous one returns.
    req_c    = rst_n && !bus.redirect && room_c && (!outstanding || bus.imem_rvalid);
    accept_c = req_c && bus.imem_gnt;
    // rvalid without a tracked request (e.g. just after reset) is ignored.
    resp_c   = bus.imem_rvalid && outstanding;
    push_c   = resp_c && (state == FETCH_RUN) && !bus.redirect;

    if (accept_c) begin
      outstanding_d = 1'b1;
      pend_pc_d     = fpc;
    end else if (resp_c) begin
      outstanding_d = 1'b0;
    end

    unique case (state)
      FETCH_RUN:  if (bus.redirect && outstanding && !bus.imem_rvalid) state_d = FETCH_KILL;
      FETCH_KILL: if (bus.imem_rvalid) state_d = FETCH_RUN;
      default:    state_d = FETCH_RUN;
    endcase

    if (bus.redirect) fpc_d = word_align(bus.redirect_pc);
    else if (accept_c) fpc_d = fpc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_RUN;
      fpc         <= word_align(RESET_PC);
      pend_pc     <= '0;
      outstanding <= 1'b0;
    end else begin
      state       <= state_d;
      fpc         <= fpc_d;
      pend_pc     <= pend_pc_d;
      outstanding <= outstanding_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (wentry),
    .pop   (pop_c),
    .flush (bus.redirect),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.imem_req   = req_c;
  assign bus.imem_addr  = word_align(fpc);
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_out   = head.inst;
  assign bus.inst_pc    = head.pc;

endmodule
